// File: rtl/vec_acc_issue_pkg.sv
// Shared types and sizing helpers for the vector accelerator issue queue.
// Optional stall counter is enabled with VEC_ACC_ISSUE_PERF_EN.
package vec_acc_issue_pkg;

  localparam int unsigned VEC_ACC_XLEN       = 64;
  localparam int unsigned VEC_ACC_TRANS_ID_W = 3;
  localparam int unsigned PERF_CNT_W         = 32;

  typedef struct packed {
    logic [31:0]                   insn;
    logic [VEC_ACC_XLEN-1:0]       rs1;
    logic [VEC_ACC_XLEN-1:0]       rs2;
    logic [VEC_ACC_TRANS_ID_W-1:0] trans_id;
  } vec_acc_entry_t;

  // One extra MSB beyond the index distinguishes full from empty.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vec_acc_issue_queue_outstanding_ctr.sv
// Up/down counter of accelerator requests awaiting a response, with limit compare.
// Part of vec_acc_issue_queue (optional feature macro VEC_ACC_ISSUE_PERF_EN lives in the top).
module vec_acc_outstanding_ctr #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] count_o,
  output logic             at_limit_o
);

  logic [CNT_W-1:0] count_d, count_q;
  logic             dec_eff;

  // A response with nothing outstanding is dropped so the count cannot underflow.
  assign dec_eff = dec_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_eff) begin
      count_d = count_q + CNT_W'(1);
    end else if (dec_eff && !inc_i) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign at_limit_o = (count_q >= limit_i);

  assert property (@(posedge clk_i) disable iff (rst_i) !(dec_i && (count_q == '0)))
    else $error("vec_acc_outstanding_ctr: response with no outstanding request");

endmodule

// File: rtl/vec_acc_issue_queue.sv
// Speculative vector-instruction queue between CVA6 issue and the Ara accelerator.
// Define VEC_ACC_ISSUE_PERF_EN to add the saturating stall counter (perf_clr_i/perf_stall_cnt_o).
module vec_acc_issue_queue
  import vec_acc_issue_pkg::*;
#(
  parameter int unsigned XLEN            = VEC_ACC_XLEN,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned TRANS_ID_W      = VEC_ACC_TRANS_ID_W,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  enq_valid_i,
  output logic                  enq_ready_o,
  input  logic [31:0]           enq_insn_i,
  input  logic [XLEN-1:0]       enq_rs1_i,
  input  logic [XLEN-1:0]       enq_rs2_i,
  input  logic [TRANS_ID_W-1:0] enq_trans_id_i,
  input  logic                  commit_i,
  output logic                  acc_req_valid_o,
  input  logic                  acc_req_ready_i,
  output logic [31:0]           acc_req_insn_o,
  output logic [XLEN-1:0]       acc_req_rs1_o,
  output logic [XLEN-1:0]       acc_req_rs2_o,
  output logic [TRANS_ID_W-1:0] acc_req_trans_id_o,
  input  logic                  acc_resp_valid_i,
  output logic                  empty_o,
  output logic                  idle_o
`ifdef VEC_ACC_ISSUE_PERF_EN
  ,
  input  logic                  perf_clr_i,
  output logic [PERF_CNT_W-1:0] perf_stall_cnt_o
`endif
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  vec_acc_entry_t   mem_d [DEPTH];
  vec_acc_entry_t   mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] cmt_ptr_d, cmt_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [PTR_W-1:0] n_total, n_uncmt, n_cmt;
  logic             enq_fire, commit_fire, issue_fire;
  logic [CNT_W-1:0] outstanding;
  logic             at_limit;
  vec_acc_entry_t   head;

  assign n_total = wr_ptr_q - rd_ptr_q;
  assign n_uncmt = wr_ptr_q - cmt_ptr_q;
  assign n_cmt   = cmt_ptr_q - rd_ptr_q;

  // n_total never exceeds DEPTH, so its MSB alone marks a full queue.
  assign enq_ready_o = ~n_total[PTR_W-1] & ~flush_i;
  assign enq_fire    = enq_valid_i & enq_ready_o;
  assign commit_fire = commit_i & (n_uncmt != '0);

  assign acc_req_valid_o = (n_cmt != '0) & ~at_limit;
  assign issue_fire      = acc_req_valid_o & acc_req_ready_i;

  assign head               = mem_q[rd_ptr_q[IDX_W-1:0]];
  assign acc_req_insn_o     = head.insn;
  assign acc_req_rs1_o      = head.rs1;
  assign acc_req_rs2_o      = head.rs2;
  assign acc_req_trans_id_o = head.trans_id;

  assign empty_o = (n_total == '0);
  assign idle_o  = empty_o & (outstanding == '0);

  always_comb begin
    mem_d     = mem_q;
    cmt_ptr_d = cmt_ptr_q + PTR_W'(commit_fire);
    rd_ptr_d  = rd_ptr_q + PTR_W'(issue_fire);
    wr_ptr_d  = wr_ptr_q + PTR_W'(enq_fire);
    if (enq_fire) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = '{insn:     enq_insn_i,
                                     rs1:      enq_rs1_i,
                                     rs2:      enq_rs2_i,
                                     trans_id: enq_trans_id_i};
    end
    // Flush rewinds to the post-commit pointer so a same-cycle commit survives.
    if (flush_i) begin
      wr_ptr_d = cmt_ptr_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      cmt_ptr_q <= '0;
      rd_ptr_q  <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  vec_acc_outstanding_ctr #(
    .CNT_W (CNT_W)
  ) u_outstanding_ctr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc_i      (issue_fire),
    .dec_i      (acc_resp_valid_i),
    .limit_i    (CNT_W'(MAX_OUTSTANDING)),
    .count_o    (outstanding),
    .at_limit_o (at_limit)
  );

`ifdef VEC_ACC_ISSUE_PERF_EN
  logic [PERF_CNT_W-1:0] perf_cnt_d, perf_cnt_q;
  logic                  stall;

  assign stall = ((n_cmt != '0) & ~acc_req_valid_o) | (acc_req_valid_o & ~acc_req_ready_i);

  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (perf_clr_i) begin
      perf_cnt_d = '0;
    end else if (stall && (perf_cnt_q != '1)) begin
      perf_cnt_d = perf_cnt_q + PERF_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_cnt_q <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_stall_cnt_o = perf_cnt_q;
`endif

  assert property (@(posedge clk_i) disable iff (rst_i) !(commit_i && (n_uncmt == '0)))
    else $error("vec_acc_issue_queue: commit with no uncommitted entry");

endmodule

// File: tb/tb_vec_acc_issue_queue.sv
// Directed self-checking bench for vec_acc_issue_queue; perf checks compile in with VEC_ACC_ISSUE_PERF_EN.
module tb_vec_acc_issue_queue;

  localparam int unsigned XLEN = 64;
  localparam int unsigned TIDW = 3;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic            enq_valid_i;
  logic            enq_ready_o;
  logic [31:0]     enq_insn_i;
  logic [XLEN-1:0] enq_rs1_i;
  logic [XLEN-1:0] enq_rs2_i;
  logic [TIDW-1:0] enq_trans_id_i;
  logic            commit_i;
  logic            acc_req_valid_o;
  logic            acc_req_ready_i;
  logic [31:0]     acc_req_insn_o;
  logic [XLEN-1:0] acc_req_rs1_o;
  logic [XLEN-1:0] acc_req_rs2_o;
  logic [TIDW-1:0] acc_req_trans_id_o;
  logic            acc_resp_valid_i;
  logic            empty_o;
  logic            idle_o;
`ifdef VEC_ACC_ISSUE_PERF_EN
  logic            perf_clr_i;
  logic [31:0]     perf_stall_cnt_o;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  vec_acc_issue_queue #(
    .XLEN            (64),
    .DEPTH           (8),
    .TRANS_ID_W      (3),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .flush_i            (flush_i),
    .enq_valid_i        (enq_valid_i),
    .enq_ready_o        (enq_ready_o),
    .enq_insn_i         (enq_insn_i),
    .enq_rs1_i          (enq_rs1_i),
    .enq_rs2_i          (enq_rs2_i),
    .enq_trans_id_i     (enq_trans_id_i),
    .commit_i           (commit_i),
    .acc_req_valid_o    (acc_req_valid_o),
    .acc_req_ready_i    (acc_req_ready_i),
    .acc_req_insn_o     (acc_req_insn_o),
    .acc_req_rs1_o      (acc_req_rs1_o),
    .acc_req_rs2_o      (acc_req_rs2_o),
    .acc_req_trans_id_o (acc_req_trans_id_o),
    .acc_resp_valid_i   (acc_resp_valid_i),
    .empty_o            (empty_o),
    .idle_o             (idle_o)
`ifdef VEC_ACC_ISSUE_PERF_EN
    ,
    .perf_clr_i         (perf_clr_i),
    .perf_stall_cnt_o   (perf_stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1ns after the rising edge, inputs change at the same point.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Entry with tag t: insn 0x100+t, rs1 0x1000+t, rs2 0x2000+t, trans_id t mod 8.
  task automatic set_enq(input int unsigned t);
    enq_valid_i    = 1'b1;
    enq_insn_i     = 32'h100 + t;
    enq_rs1_i      = 64'h1000 + t;
    enq_rs2_i      = 64'h2000 + t;
    enq_trans_id_i = TIDW'(t);
  endtask

  task automatic chk_head(input string tag, input int unsigned t);
    chk({tag, "_valid"}, 64'(acc_req_valid_o), 64'd1);
    chk({tag, "_insn"}, 64'(acc_req_insn_o), 64'h100 + t);
    chk({tag, "_tid"}, 64'(acc_req_trans_id_o), 64'(t % 8));
  endtask

  initial begin
    rst_i            = 1'b1;
    flush_i          = 1'b0;
    enq_valid_i      = 1'b0;
    enq_insn_i       = '0;
    enq_rs1_i        = '0;
    enq_rs2_i        = '0;
    enq_trans_id_i   = '0;
    commit_i         = 1'b0;
    acc_req_ready_i  = 1'b0;
    acc_resp_valid_i = 1'b0;
`ifdef VEC_ACC_ISSUE_PERF_EN
    perf_clr_i       = 1'b0;
`endif
    tick();
    tick();
    rst_i = 1'b0;
    tick();

    // Reset / idle
    chk("rst_valid", 64'(acc_req_valid_o), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready_o), 64'd1);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_idle", 64'(idle_o), 64'd1);
    chk("rst_insn", 64'(acc_req_insn_o), 64'd0);
    chk("rst_rs1", acc_req_rs1_o, 64'd0);

    // Three entries, single commit exposes only the oldest
    set_enq(0); tick();
    chk("enq0_empty", 64'(empty_o), 64'd0);
    chk("enq0_valid", 64'(acc_req_valid_o), 64'd0);
    set_enq(1); tick();
    set_enq(2); tick();
    enq_valid_i = 1'b0;
    chk("uncmt_valid", 64'(acc_req_valid_o), 64'd0);
    commit_i = 1'b1; tick(); commit_i = 1'b0;
    chk_head("c1_head", 0);
    chk("c1_rs1", acc_req_rs1_o, 64'h1000);
    chk("c1_rs2", acc_req_rs2_o, 64'h2000);
    tick();
    chk_head("c1_hold", 0);
    commit_i = 1'b1; acc_req_ready_i = 1'b1; tick();
    chk_head("c2_head", 1);
    chk("c2_idle", 64'(idle_o), 64'd0);
    tick();
    commit_i = 1'b0;
    chk_head("c3_head", 2);
    tick();
    acc_req_ready_i = 1'b0;
    chk("drain_valid", 64'(acc_req_valid_o), 64'd0);
    chk("drain_empty", 64'(empty_o), 64'd1);
    chk("drain_idle", 64'(idle_o), 64'd0);
    acc_resp_valid_i = 1'b1; tick(); tick(); tick(); acc_resp_valid_i = 1'b0;
    chk("t2_idle", 64'(idle_o), 64'd1);

    // Fill to DEPTH, commit all, issue up to the outstanding limit
    for (int i = 0; i < 7; i++) begin
      set_enq(8 + i); tick();
    end
    chk("fill7_ready", 64'(enq_ready_o), 64'd1);
    set_enq(15); tick();
    chk("fill8_ready", 64'(enq_ready_o), 64'd0);
    set_enq(16); tick();
    enq_valid_i = 1'b0;
    commit_i = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    commit_i = 1'b0;
    chk_head("full_head", 8);
    chk("full_ready", 64'(enq_ready_o), 64'd0);
    acc_req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_head("lim_issue", 8 + i);
      tick();
      if (i == 0) chk("room_ready", 64'(enq_ready_o), 64'd1);
    end
    chk("lim_stall_valid", 64'(acc_req_valid_o), 64'd0);
    chk("lim_stall_empty", 64'(empty_o), 64'd0);
    acc_resp_valid_i = 1'b1;
    tick();
    for (int i = 4; i < 8; i++) begin
      chk_head("lim_resume", 8 + i);
      tick();
    end
    acc_req_ready_i = 1'b0;
    chk("lim_done_empty", 64'(empty_o), 64'd1);
    chk("lim_done_valid", 64'(acc_req_valid_o), 64'd0);
    tick(); tick(); tick();
    acc_resp_valid_i = 1'b0;
    chk("t3_idle", 64'(idle_o), 64'd1);

    // Flush with same-cycle commit: 2 committed + 1 committing survive
    for (int i = 0; i < 5; i++) begin
      set_enq(20 + i); tick();
    end
    enq_valid_i = 1'b0;
    commit_i = 1'b1; tick(); tick();
    flush_i = 1'b1;
    set_enq(25);
    #1;
    chk("flush_enq_ready", 64'(enq_ready_o), 64'd0);
    tick();
    flush_i = 1'b0; commit_i = 1'b0; enq_valid_i = 1'b0;
    acc_req_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_head("flush_keep", 20 + i);
      tick();
    end
    acc_req_ready_i = 1'b0;
    chk("flush_valid", 64'(acc_req_valid_o), 64'd0);
    chk("flush_empty", 64'(empty_o), 64'd1);
    acc_resp_valid_i = 1'b1; tick(); tick(); tick(); acc_resp_valid_i = 1'b0;
    set_enq(26); tick();
    enq_valid_i = 1'b0;
    commit_i = 1'b1; tick(); commit_i = 1'b0;
    chk_head("post_flush", 26);
    acc_req_ready_i = 1'b1; tick(); acc_req_ready_i = 1'b0;
    acc_resp_valid_i = 1'b1; tick(); acc_resp_valid_i = 1'b0;
    chk("t4_idle", 64'(idle_o), 64'd1);

    // Pointer wrap: 20 single-entry round trips
    for (int i = 0; i < 20; i++) begin
      set_enq(40 + i); tick();
      enq_valid_i = 1'b0;
      commit_i = 1'b1; tick(); commit_i = 1'b0;
      chk("wrap_insn", 64'(acc_req_insn_o), 64'h100 + 64'(40 + i));
      acc_req_ready_i = 1'b1; tick(); acc_req_ready_i = 1'b0;
      acc_resp_valid_i = 1'b1; tick(); acc_resp_valid_i = 1'b0;
    end
    chk("wrap_empty", 64'(empty_o), 64'd1);
    chk("wrap_idle", 64'(idle_o), 64'd1);

`ifdef VEC_ACC_ISSUE_PERF_EN
    // Stall counter: 10 cycles of valid & ~ready
    set_enq(60); tick();
    enq_valid_i = 1'b0;
    commit_i = 1'b1; tick(); commit_i = 1'b0;
    perf_clr_i = 1'b1; tick(); perf_clr_i = 1'b0;
    chk("perf_clr0", 64'(perf_stall_cnt_o), 64'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("perf_cnt10", 64'(perf_stall_cnt_o), 64'd10);
    perf_clr_i = 1'b1; tick(); perf_clr_i = 1'b0;
    chk("perf_clr1", 64'(perf_stall_cnt_o), 64'd0);
    acc_req_ready_i = 1'b1; tick(); acc_req_ready_i = 1'b0;
    acc_resp_valid_i = 1'b1; tick(); acc_resp_valid_i = 1'b0;
`endif

    // Asynchronous reset mid-operation
    set_enq(70); tick();
    set_enq(71); tick();
    enq_valid_i = 1'b0;
    commit_i = 1'b1; tick(); tick(); commit_i = 1'b0;
    acc_req_ready_i = 1'b1; tick(); acc_req_ready_i = 1'b0;
    chk_head("pre_rst", 71);
    chk("pre_rst_idle", 64'(idle_o), 64'd0);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_valid", 64'(acc_req_valid_o), 64'd0);
    chk("arst_empty", 64'(empty_o), 64'd1);
    chk("arst_idle", 64'(idle_o), 64'd1);
    chk("arst_insn", 64'(acc_req_insn_o), 64'd0);
    tick();
    rst_i = 1'b0;
    tick();
    chk("post_rst_ready", 64'(enq_ready_o), 64'd1);
    chk("post_rst_idle", 64'(idle_o), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", n_vec);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/vec_acc_issue_queue.md
Name: vec_acc_issue_queue

Overview:
- Buffers vector instructions between CVA6 issue and the RVV accelerator (Ara).
- Instructions enter speculatively and become issuable only after in-order commit.
- The accelerator request port is gated by an outstanding-request limit.
- Instantiated in the core when the user configuration has RVV set.
- Sized from the scoreboard depth and XLEN of the active cva6 config.

Parameters:
- XLEN, 64, width of the rs1/rs2 operand fields.
- DEPTH, 8, number of queue entries; power of two, ≥2; defaults to NrScoreboardEntries.
- TRANS_ID_W, 3, scoreboard transaction-id width; equals clog2(DEPTH).
- MAX_OUTSTANDING, 4, limit on requests issued to the accelerator without a response; ≥1.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  drop all uncommitted entries
- enq_valid_i  in  1  enqueue request
- enq_ready_o  out  1  queue can accept an entry
- enq_insn_i  in  32  instruction word
- enq_rs1_i  in  XLEN  operand 1
- enq_rs2_i  in  XLEN  operand 2
- enq_trans_id_i  in  TRANS_ID_W  scoreboard id
- commit_i  in  1  commit the oldest uncommitted entry
- acc_req_valid_o  out  1  request to accelerator
- acc_req_ready_i  in  1  accelerator accepts the request
- acc_req_insn_o  out  32  head instruction
- acc_req_rs1_o  out  XLEN  head operand 1
- acc_req_rs2_o  out  XLEN  head operand 2
- acc_req_trans_id_o  out  TRANS_ID_W  head id
- acc_resp_valid_i  in  1  one accelerator response retired
- empty_o  out  1  no entries held
- idle_o  out  1  empty_o and zero outstanding requests

Behaviour:
- Pointers: wr_ptr, cmt_ptr, rd_ptr, each clog2(DEPTH)+1 bits. The MSB disambiguates wrap.
- Order invariant: rd_ptr ≤ cmt_ptr ≤ wr_ptr, in modular order.
- Counters:
  - n_total = wr_ptr - rd_ptr
  - n_uncmt = wr_ptr - cmt_ptr
  - n_cmt = cmt_ptr - rd_ptr
- Reset state:
  - all pointers 0, outstanding counter 0
  - enq_ready_o=1, acc_req_valid_o=0, empty_o=1, idle_o=1
  - payload outputs 0
- Enqueue:
  - enq_ready_o = (n_total<DEPTH) & ~flush_i.
  - On enq_valid_i & enq_ready_o, write the entry at wr_ptr and increment wr_ptr.
- Commit:
  - If n_uncmt>0, commit_i increments cmt_ptr.
  - An entry enqueued in cycle N is committable from cycle N+1. A same-cycle commit applies only to older entries.
  - commit_i with n_uncmt=0 is ignored; simulation assertion fires.
- Issue:
  - acc_req_valid_o = (n_cmt>0) & (outstanding<MAX_OUTSTANDING).
  - Payload is read combinationally from the entry at rd_ptr.
  - Once valid is asserted, valid and payload hold stable until handshake. Flush cannot drop committed entries, so this is guaranteed.
  - Handshake: rd_ptr+1 and outstanding+1.
  - Latency: a commit in cycle N gives acc_req_valid_o in cycle N+1 if the entry is at the head and the outstanding limit is not reached.
- Outstanding counter:
  - acc_resp_valid_i decrements it.
  - Simultaneous issue and response leave it unchanged.
  - A response at 0 is ignored; assertion fires.
- Flush:
  - flush_i sets wr_ptr <= cmt_ptr_next, i.e. after any same-cycle commit, so the committing entry survives.
  - A same-cycle enqueue is dropped; enq_ready_o is already low.
  - Committed entries and outstanding requests are unaffected.
- Full queue: enq_ready_o=0. Same-cycle issue does not make room in that cycle; there is no combinational ready-to-ready path.
- Status outputs:
  - empty_o = (n_total==0)
  - idle_o = empty_o & (outstanding==0)
- Reset asserted mid-operation clears everything asynchronously. In-flight responses after reset are ignored.

Optional Feature:
- Macro: VEC_ACC_ISSUE_PERF_EN.
- When defined:
  - Adds output perf_stall_cnt_o [31:0], a saturating count of cycles with n_cmt>0 & ~acc_req_valid_o (outstanding-limit stall) or acc_req_valid_o & ~acc_req_ready_i.
  - Adds input perf_clr_i, a synchronous clear.
  - The counter resets to 0.
- When undefined: neither port exists and no counter logic is generated.

Decomposition:
- Package vec_acc_issue_pkg holds:
  - typedef vec_acc_entry_t {insn, rs1, rs2, trans_id}, parameterised through XLEN/TRANS_ID_W localparams
  - ptr width function
  - perf counter width constant (32)
- One sub-module, vec_acc_outstanding_ctr:
  - up/down counter with max compare
  - inputs: inc, dec, limit
  - outputs: count, at_limit

Test Plan:
- Reset then idle: no stimulus -> acc_req_valid_o=0, enq_ready_o=1, idle_o=1.
- Enqueue 3 entries (trans_id 0,1,2), commit 1 at cycle 5 -> acc_req_valid_o=1 at cycle 6 with trans_id 0; entries 1 and 2 not visible.
- Enqueue 8 entries -> enq_ready_o=0 after the 8th. Commit all, hold ready high -> issues in order 0..3, then stalls because MAX_OUTSTANDING=4. A response re-enables issue the next cycle.
- 2 committed + 3 uncommitted entries; flush_i together with commit_i -> 3 committed entries survive and issue; trans_ids of dropped entries never appear.
- Pointer wrap: 20 enqueue/commit/issue cycles with DEPTH=8 -> FIFO order preserved, empty_o=1 at end.
- Perf build (VEC_ACC_ISSUE_PERF_EN): hold acc_req_ready_i=0 for 10 cycles with 1 committed entry -> perf_stall_cnt_o=10; perf_clr_i -> 0.
